// File: rtl/puneh_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puneh_mem_pkg
// Description : Shared types and constants for the PUNEH memory responder:
//               FSM state encoding, default bus widths, wait-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package puneh_mem_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 16;
    localparam int WAIT_CNT_W = 4;

    // Largest wait count the counter can hold
    localparam int MAX_WAIT   = (1 << WAIT_CNT_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RWAIT = 2'b01,
        ST_WWAIT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Convert an integer wait parameter into a counter load value
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int w);
        return WAIT_CNT_W'(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/puneh_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : puneh_mem_responder_if
// Description : Memory-port bundle between the PUNEH controller (master) and
//               the memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface puneh_mem_responder_if #(
    parameter int ADDR_W = puneh_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = puneh_mem_pkg::DEF_DATA_W
) ();

    logic              readMEM;
    logic              writeMEM;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dataIn;
    logic [DATA_W-1:0] dataOut;
    logic              memReady;
    logic              busy;
    logic              errFlag;

    modport master (
        output readMEM, writeMEM, addr, dataIn,
        input  dataOut, memReady, busy, errFlag
    );

    modport slave (
        input  readMEM, writeMEM, addr, dataIn,
        output dataOut, memReady, busy, errFlag
    );

endinterface
`default_nettype wire

// File: rtl/puneh_mem_responder_sram.sv
`default_nettype none
// ============================================================================
// Module      : puneh_sram
// Description : Single-port synchronous word array. Read data is registered
//               (read-before-write on a same-address write). No reset: the
//               contents survive a responder reset.
// Revision    : 1.0 - initial release
// ============================================================================
module puneh_sram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Array write port and registered read port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/puneh_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : puneh_mem_responder
// Description : Memory-side responder for the PUNEH memory port. Accepts one
//               read or write at a time, waits a programmable number of
//               cycles, then completes with a one-cycle memReady pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module puneh_mem_responder
    import puneh_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    puneh_mem_responder_if.slave   bus
);

    // Wait parameters must fit the wait counter
    if (READ_WAIT < 0 || READ_WAIT > MAX_WAIT) begin : g_bad_read_wait
        $error("puneh_mem_responder: READ_WAIT out of range 0..15");
    end
    if (WRITE_WAIT < 0 || WRITE_WAIT > MAX_WAIT) begin : g_bad_write_wait
        $error("puneh_mem_responder: WRITE_WAIT out of range 0..15");
    end

    localparam logic [WAIT_CNT_W-1:0] c_read_wait  = wait_load(READ_WAIT);
    localparam logic [WAIT_CNT_W-1:0] c_write_wait = wait_load(WRITE_WAIT);
    localparam logic [WAIT_CNT_W-1:0] c_cnt_one    = wait_load(1);

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [DATA_W-1:0]   r_data_q;
    logic [DATA_W-1:0]   r_dataOut;
    logic                r_memReady;
    logic                r_busy;
    logic                r_errFlag;

    logic                w_req_rd;
    logic                w_req_wr;
    logic                w_req_err;
    logic                w_cnt_zero;
    logic                w_sram_we;
    logic [ADDR_W-1:0]   w_sram_addr;
    logic [DATA_W-1:0]   w_sram_rdata;

    assign w_req_rd   = bus.readMEM  & ~bus.writeMEM;
    assign w_req_wr   = bus.writeMEM & ~bus.readMEM;
    assign w_req_err  = bus.readMEM  &  bus.writeMEM;
    assign w_cnt_zero = (r_cnt == '0);

    // In IDLE the array is addressed straight from the bus so that the read
    // data is already registered by the first wait cycle; this lets a
    // zero-wait read complete one edge after accept. Afterwards the latched
    // address holds the access steady regardless of bus activity.
    assign w_sram_addr = (r_state == ST_IDLE) ? bus.addr : r_addr_q;
    assign w_sram_we   = (r_state == ST_WWAIT) && w_cnt_zero;

    puneh_sram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_sram_we),
        .i_addr  (w_sram_addr),
        .i_wdata (r_data_q),
        .o_rdata (w_sram_rdata)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; DONE always returns to IDLE, swallowing the
    // cycle in which the initiator drops its strobe
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_rd) begin
                    w_next = ST_RWAIT;
                end else if (w_req_wr) begin
                    w_next = ST_WWAIT;
                end
            end
            ST_RWAIT: begin
                if (w_cnt_zero) begin
                    w_next = ST_DONE;
                end
            end
            ST_WWAIT: begin
                if (w_cnt_zero) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latches, wait counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_addr_q   <= '0;
            r_data_q   <= '0;
            r_dataOut  <= '0;
            r_memReady <= 1'b0;
            r_busy     <= 1'b0;
            r_errFlag  <= 1'b0;
        end else begin
            r_memReady <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_rd) begin
                        r_addr_q <= bus.addr;
                        r_cnt    <= c_read_wait;
                        r_busy   <= 1'b1;
                    end else if (w_req_wr) begin
                        r_addr_q <= bus.addr;
                        r_data_q <= bus.dataIn;
                        r_cnt    <= c_write_wait;
                        r_busy   <= 1'b1;
                    end else if (w_req_err) begin
                        r_errFlag <= 1'b1;
                    end
                end
                ST_RWAIT: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else begin
                        r_dataOut  <= w_sram_rdata;
                        r_memReady <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                ST_WWAIT: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else begin
                        r_memReady <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.dataOut  = r_dataOut;
    assign bus.memReady = r_memReady;
    assign bus.busy     = r_busy;
    assign bus.errFlag  = r_errFlag;

endmodule
`default_nettype wire
